// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM/WB inputs, data memory read data and register file write port.
interface wb_stage_if #(
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned CNT_SIZE  = 32
);
    logic                 stall;
    logic                 flush;
    logic                 in_valid;
    logic                 in_wr_en;
    logic [ADDR_SIZE-1:0] in_rd_addr;
    logic [WORD_SIZE-1:0] in_alu_result;
    logic                 in_mem_to_reg;
    logic [2:0]           in_load_type;
    logic [1:0]           in_byte_off;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 rd_en;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 fwd_valid;
    logic [CNT_SIZE-1:0]  retired;

    // Pipeline control / MEM stage side
    modport master (
        output stall, flush, in_valid, in_wr_en, in_rd_addr, in_alu_result,
               in_mem_to_reg, in_load_type, in_byte_off, mem_rdata,
        input  rd_en, rd_addr, rd_data, fwd_valid, retired
    );

    // Writeback stage side
    modport slave (
        input  stall, flush, in_valid, in_wr_en, in_rd_addr, in_alu_result,
               in_mem_to_reg, in_load_type, in_byte_off, mem_rdata,
        output rd_en, rd_addr, rd_data, fwd_valid, retired
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB register, big-endian sub-word load extraction,
// register file write port, forwarding qualifier and retired-instruction counter.
module wb_stage #(
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned WORD_SIZE = 32,  // byte/halfword extraction assumes 32
    parameter int unsigned CNT_SIZE  = 32
) (
    input logic        clk,
    input logic        rst,
    wb_stage_if.slave  bus
);
    localparam logic [2:0] LdLb  = 3'b001;
    localparam logic [2:0] LdLbu = 3'b010;
    localparam logic [2:0] LdLh  = 3'b011;
    localparam logic [2:0] LdLhu = 3'b100;

    logic                 valid_q, valid_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [WORD_SIZE-1:0] alu_q, alu_d;
    logic                 mem_to_reg_q, mem_to_reg_d;
    logic [2:0]           load_type_q, load_type_d;
    logic [1:0]           byte_off_q, byte_off_d;
    logic [CNT_SIZE-1:0]  retired_q, retired_d;

    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [WORD_SIZE-1:0] load_value;

    // MEM/WB register next state: flush beats stall, stall holds, otherwise capture
    always_comb begin
        valid_d      = valid_q;
        wr_en_d      = wr_en_q;
        rd_addr_d    = rd_addr_q;
        alu_d        = alu_q;
        mem_to_reg_d = mem_to_reg_q;
        load_type_d  = load_type_q;
        byte_off_d   = byte_off_q;
        retired_d    = retired_q;
        if (bus.flush) begin
            valid_d      = 1'b0;
            wr_en_d      = 1'b0;
            rd_addr_d    = '0;
            alu_d        = '0;
            mem_to_reg_d = 1'b0;
            load_type_d  = '0;
            byte_off_d   = '0;
        end else if (!bus.stall) begin
            valid_d      = bus.in_valid;
            wr_en_d      = bus.in_wr_en;
            rd_addr_d    = bus.in_rd_addr;
            alu_d        = bus.in_alu_result;
            mem_to_reg_d = bus.in_mem_to_reg;
            load_type_d  = bus.in_load_type;
            byte_off_d   = bus.in_byte_off;
        end
        // An instruction retires only when it actually leaves WB
        if (valid_q && !bus.stall && !bus.flush) begin
            retired_d = retired_q + CNT_SIZE'(1);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            alu_q        <= '0;
            mem_to_reg_q <= 1'b0;
            load_type_q  <= '0;
            byte_off_q   <= '0;
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            wr_en_q      <= wr_en_d;
            rd_addr_q    <= rd_addr_d;
            alu_q        <= alu_d;
            mem_to_reg_q <= mem_to_reg_d;
            load_type_q  <= load_type_d;
            byte_off_q   <= byte_off_d;
            retired_q    <= retired_d;
        end
    end

    // Big-endian sub-word extraction from the synchronous memory read data
    always_comb begin
        unique case (byte_off_q)
            2'd0:    byte_sel = bus.mem_rdata[31:24];
            2'd1:    byte_sel = bus.mem_rdata[23:16];
            2'd2:    byte_sel = bus.mem_rdata[15:8];
            default: byte_sel = bus.mem_rdata[7:0];
        endcase
        half_sel = byte_off_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
        case (load_type_q)
            LdLb:    load_value = {{(WORD_SIZE-8){byte_sel[7]}}, byte_sel};
            LdLbu:   load_value = {{(WORD_SIZE-8){1'b0}}, byte_sel};
            LdLh:    load_value = {{(WORD_SIZE-16){half_sel[15]}}, half_sel};
            LdLhu:   load_value = {{(WORD_SIZE-16){1'b0}}, half_sel};
            default: load_value = bus.mem_rdata;  // LW and reserved codes
        endcase
    end

    // Register file write port; $0 writes are suppressed
    always_comb begin
        bus.rd_en     = valid_q & wr_en_q & (rd_addr_q != '0);
        bus.fwd_valid = bus.rd_en;
        bus.rd_addr   = rd_addr_q;
        bus.rd_data   = mem_to_reg_q ? load_value : alu_q;
        bus.retired   = retired_q;
    end
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a driver updates a reference model at each edge and
// queues the expected outputs; a monitor pops and compares on every falling edge.
module tb_wb_stage;
    logic clk;
    logic rst;

    wb_stage_if #(.ADDR_SIZE(5), .WORD_SIZE(32), .CNT_SIZE(32)) bif ();
    wb_stage_if #(.ADDR_SIZE(5), .WORD_SIZE(32), .CNT_SIZE(4))  sif ();

    wb_stage #(.ADDR_SIZE(5), .WORD_SIZE(32), .CNT_SIZE(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Narrow-counter copy fed with identical stimulus to exercise wrap
    wb_stage #(.ADDR_SIZE(5), .WORD_SIZE(32), .CNT_SIZE(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    assign sif.stall         = bif.stall;
    assign sif.flush         = bif.flush;
    assign sif.in_valid      = bif.in_valid;
    assign sif.in_wr_en      = bif.in_wr_en;
    assign sif.in_rd_addr    = bif.in_rd_addr;
    assign sif.in_alu_result = bif.in_alu_result;
    assign sif.in_mem_to_reg = bif.in_mem_to_reg;
    assign sif.in_load_type  = bif.in_load_type;
    assign sif.in_byte_off   = bif.in_byte_off;
    assign sif.mem_rdata     = bif.mem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [31:0] ret;
        logic [3:0]  ret_small;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: the instruction currently sitting in WB
    bit          m_valid, m_wr, m_m2r;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdata;
    logic [2:0]  m_lt;
    logic [1:0]  m_off;
    longint      m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Big-endian load semantics with plain arithmetic
    function automatic logic [31:0] load_ref(input logic [2:0] lt, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned o, b, h;
        o = off;
        b = (w >> (8 * (3 - o))) & 32'hFF;
        h = (w >> (16 * (1 - o / 2))) & 32'hFFFF;
        case (lt)
            3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wr = 0; m_m2r = 0; m_rd = '0; m_alu = '0; m_lt = '0; m_off = '0;
        m_ret = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.rd_en     = m_valid && m_wr && (m_rd != 0);
        e.rd_addr   = m_rd;
        e.rd_data   = m_m2r ? load_ref(m_lt, m_off, m_rdata) : m_alu;
        e.ret       = 32'(m_ret % 64'h1_0000_0000);
        e.ret_small = 4'(m_ret % 16);
        exp_q.push_back(e);
    endtask

    // Present one MEM-stage beat, clock it in, then supply the WB-cycle memory data
    task automatic cycle(input bit v, input bit w, input logic [4:0] rd, input logic [31:0] alu,
                         input bit m2r, input logic [2:0] lt, input logic [1:0] off,
                         input bit st, input bit fl, input logic [31:0] rdata);
        bif.in_valid = v; bif.in_wr_en = w; bif.in_rd_addr = rd; bif.in_alu_result = alu;
        bif.in_mem_to_reg = m2r; bif.in_load_type = lt; bif.in_byte_off = off;
        bif.stall = st; bif.flush = fl;
        @(posedge clk);
        if (m_valid && !st && !fl) m_ret++;
        if (fl) begin
            m_valid = 0; m_wr = 0; m_m2r = 0; m_rd = '0; m_alu = '0; m_lt = '0; m_off = '0;
        end else if (!st) begin
            m_valid = v; m_wr = w; m_rd = rd; m_alu = alu; m_m2r = m2r; m_lt = lt; m_off = off;
        end
        #1;
        bif.mem_rdata = rdata;
        m_rdata = rdata;
        push_exp();
    endtask

    // Reset asserted between edges must clear outputs without a clock
    task automatic reset_mid();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_rd_en", 32'(bif.rd_en), 32'd0);
        chk("async_rst_fwd_valid", 32'(bif.fwd_valid), 32'd0);
        chk("async_rst_rd_addr", 32'(bif.rd_addr), 32'd0);
        chk("async_rst_rd_data", bif.rd_data, 32'd0);
        chk("async_rst_retired", bif.retired, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp();
    endtask

    // Monitor: compare DUT outputs against the oldest expectation on each falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rd_en", 32'(bif.rd_en), 32'(e.rd_en));
            chk("fwd_valid", 32'(bif.fwd_valid), 32'(e.rd_en));
            chk("rd_addr", 32'(bif.rd_addr), 32'(e.rd_addr));
            chk("rd_data", bif.rd_data, e.rd_data);
            chk("retired", bif.retired, e.ret);
            chk("retired_small", 32'(sif.retired), 32'(e.ret_small));
        end
    end

    localparam logic [31:0] LdWord = 32'h80FF_7F01;

    initial begin
        logic [2:0]  t_lt  [7];
        logic [1:0]  t_off [7];
        logic [31:0] t_exp [7];
        t_lt  = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd3, 3'd0};
        t_off = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd2};
        t_exp = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_007F, 32'h0000_7F01,
                  32'h0000_80FF, 32'h0000_7F01, 32'h80FF_7F01};

        rst = 1'b1;
        bif.stall = 0; bif.flush = 0; bif.in_valid = 0; bif.in_wr_en = 0;
        bif.in_rd_addr = '0; bif.in_alu_result = '0; bif.in_mem_to_reg = 0;
        bif.in_load_type = '0; bif.in_byte_off = '0; bif.mem_rdata = '0;
        model_reset();
        m_rdata = '0;
        @(posedge clk); #1; push_exp();
        @(posedge clk); #1; rst = 1'b0; push_exp();

        // ALU write
        cycle(1, 1, 5'd5, 32'h1234_5678, 0, 3'd0, 2'd0, 0, 0, 32'hDEAD_BEEF);
        #4;
        chk("alu_rd_data", bif.rd_data, 32'h1234_5678);
        chk("alu_rd_en", 32'(bif.rd_en), 32'd1);

        // Loads from a fixed word
        for (int i = 0; i < 7; i++) begin
            cycle(1, 1, 5'd9, 32'h0000_1000, 1, t_lt[i], t_off[i], 0, 0, LdWord);
            #4;
            chk("load_value", bif.rd_data, t_exp[i]);
        end

        // $0 write suppressed, still retires
        cycle(1, 1, 5'd0, 32'hAAAA_5555, 0, 3'd0, 2'd0, 0, 0, 32'h0);
        #4;
        chk("zero_reg_rd_en", 32'(bif.rd_en), 32'd0);

        // Capture r7, stall three edges with changing inputs, then flush under stall
        cycle(1, 1, 5'd7, 32'h7777_0007, 0, 3'd0, 2'd0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 5'(i + 20), $urandom, 1, 3'd1, 2'd1, 1, 0, $urandom);
        end
        #4;
        chk("stall_hold_rd_addr", 32'(bif.rd_addr), 32'd7);
        cycle(1, 1, 5'd3, 32'h3, 0, 3'd0, 2'd0, 1, 1, 32'h0);
        #4;
        chk("flush_rd_en", 32'(bif.rd_en), 32'd0);

        // Async reset while a write is pending
        cycle(1, 1, 5'd12, 32'hCAFE_F00D, 0, 3'd0, 2'd0, 0, 0, 32'h0);
        reset_mid();

        // 17 counted edges wrap a 4-bit counter to 1
        for (int i = 0; i < 18; i++) begin
            cycle(1, 1, 5'(i + 1), 32'(i), 0, 3'd0, 2'd0, 0, 0, 32'h0);
        end
        #4;
        chk("wrap_retired_small", 32'(sif.retired), 32'd1);
        chk("wrap_retired", bif.retired, 32'd17);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 8), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                  $urandom, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 9) < 1), $urandom);
        end
        cycle(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0, 0, 0, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
